// File: rtl/mem_word_seq.sv
// ============================================================================
// Module      : mem_word_seq
// Description : Splits one 32-bit word request into four little-endian byte
//               accesses on a byte-wide memory port and assembles read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_word_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_adr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic [WIDTH-1:0] mem_adr,
  output logic [7:0]       mem_writedata,
  output logic             mem_memwrite,
  input  logic [7:0]       mem_memdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [31:0]      wbuf_q, wbuf_d;
  logic [31:0]      rbuf_q, rbuf_d;
  logic             wr_q, wr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      base_q  <= '0;
      wbuf_q  <= 32'd0;
      rbuf_q  <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_XFER;
      S_XFER:  if (cnt_q == 2'd3) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and per-byte datapath; cnt wraps 3->0 on the last byte.
  always_comb begin
    cnt_d  = cnt_q;
    base_d = base_q;
    wbuf_d = wbuf_q;
    rbuf_d = rbuf_q;
    wr_d   = wr_q;
    if (state_q == S_IDLE && req_valid) begin
      base_d = req_adr & ALIGN_MASK;
      wbuf_d = req_wdata;
      wr_d   = req_write;
      cnt_d  = 2'd0;
    end else if (state_q == S_XFER) begin
      cnt_d = cnt_q + 2'd1;
      if (!wr_q) rbuf_d[{cnt_q, 3'b000} +: 8] = mem_memdata;
    end
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE);
    rsp_valid     = (state_q == S_DONE);
    rsp_rdata     = rbuf_q;
    mem_adr       = base_q;
    mem_writedata = 8'd0;
    mem_memwrite  = 1'b0;
    if (state_q == S_XFER) begin
      mem_adr = base_q | {{(WIDTH-2){1'b0}}, cnt_q};
      if (wr_q) begin
        mem_memwrite  = 1'b1;
        mem_writedata = wbuf_q[{cnt_q, 3'b000} +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_word_seq.sv
// ============================================================================
// Module      : tb_mem_word_seq
// Description : Self-checking bench for mem_word_seq with a transaction-level
//               reference model and a byte-wide memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_word_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_ready, req_write;
  logic [W-1:0] req_adr;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic [W-1:0] mem_adr;
  logic [7:0]   mem_writedata;
  logic         mem_memwrite;
  logic [7:0]   mem_memdata;

  always #5 clk = ~clk;

  mem_word_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_adr(mem_adr), .mem_writedata(mem_writedata),
    .mem_memwrite(mem_memwrite), .mem_memdata(mem_memdata)
  );

  // External byte memory driven by the DUT
  logic [7:0] mem [0:255];
  assign mem_memdata = mem[mem_adr];
  always @(posedge clk) if (mem_memwrite) mem[mem_adr] <= mem_writedata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: k counts cycles since the accept edge (0 = idle, 5 = response)
  logic [7:0]   ref_mem [0:255];
  int           k = 0;
  int           n_acc = 0;
  logic [W-1:0] m_base;
  logic [31:0]  m_wdata, m_rd, m_last;
  logic         m_wr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k      <= 0;
      m_last <= 32'd0;
      m_base <= '0;
      m_wr   <= 1'b0;
    end else if (k == 0) begin
      if (req_valid) begin
        int a;
        a = int'(req_adr) / 4 * 4;
        k       <= 1;
        n_acc   <= n_acc + 1;
        m_base  <= W'(a);
        m_wr    <= req_write;
        m_wdata <= req_wdata;
        m_rd    <= {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      end
    end else begin
      if (k <= 4 && m_wr) ref_mem[int'(m_base) + k - 1] <= m_wdata[8*(k-1) +: 8];
      if (k == 4 && !m_wr) m_last <= m_rd;
      k <= (k == 5) ? 0 : k + 1;
    end
  end

  bit chk_en = 0;
  int dut_acc = 0;
  logic [W+8:0] obs [$];

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      logic         xfer;
      logic [31:0]  er;
      logic [7:0]   ewd;
      int           ea;
      xfer = (k >= 1 && k <= 4);
      ea   = int'(m_base) + (xfer ? k - 1 : 0);
      ewd  = (xfer && m_wr) ? m_wdata[8*(k-1) +: 8] : 8'd0;
      er   = m_last;
      if (xfer && !m_wr)
        for (int i = 0; i < 4; i++) if (i < k - 1) er[8*i +: 8] = m_rd[8*i +: 8];
      check("req_ready",     {31'd0, req_ready},     {31'd0, k == 0});
      check("rsp_valid",     {31'd0, rsp_valid},     {31'd0, k == 5});
      check("mem_adr",       {24'd0, mem_adr},       {24'd0, ea[7:0]});
      check("mem_memwrite",  {31'd0, mem_memwrite},  {31'd0, xfer && m_wr});
      check("mem_writedata", {24'd0, mem_writedata}, {24'd0, ewd});
      check("rsp_rdata",     rsp_rdata,              er);
      if (xfer) obs.push_back({mem_memwrite, mem_adr, mem_writedata});
      if (req_ready && req_valid) dut_acc++;
    end
  end

  task automatic do_req(input logic wr, input logic [7:0] adr, input logic [31:0] wd,
                        output logic [31:0] rd);
    bit got;
    int n;
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = wr; req_adr = adr; req_wdata = wd;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
      @(posedge clk); #2;
    end
    req_valid = 1'b0; req_write = 1'($urandom); req_adr = 8'($urandom); req_wdata = $urandom;
    rd = 32'd0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 12 cycles");
      return;
    end
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("rsp_latency", n, 5);
    rd = rsp_rdata;
  endtask

  logic [31:0] rd;
  logic [31:0] w;

  initial begin
    reset_n = 1'b1;
    req_valid = 1'($urandom); req_write = 1'($urandom);
    req_adr = 8'($urandom); req_wdata = $urandom;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i] <= v; ref_mem[i] <= v;
    end
    for (int i = 0; i < 4; i++) begin
      mem[8'h30 + i] <= 8'hFF; ref_mem[8'h30 + i] <= 8'hFF;
    end
    w = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      mem[8'hFC + i] <= w[8*i +: 8]; ref_mem[8'hFC + i] <= w[8*i +: 8];
    end

    // Test 1: asynchronous reset mid-cycle
    #7 reset_n = 1'b0;
    #1;
    check("rst_req_ready",    {31'd0, req_ready},     32'd1);
    check("rst_rsp_valid",    {31'd0, rsp_valid},     32'd0);
    check("rst_memwrite",     {31'd0, mem_memwrite},  32'd0);
    check("rst_mem_adr",      {24'd0, mem_adr},       32'd0);
    check("rst_writedata",    {24'd0, mem_writedata}, 32'd0);
    check("rst_rsp_rdata",    rsp_rdata,              32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1; req_valid = 1'b0; chk_en = 1;

    // Test 2: word write, byte order and strobes
    obs.delete();
    w = 32'hA1B2C3D4;
    do_req(1'b1, 8'h10, w, rd);
    check("wr_obs_count", obs.size(), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++)
      check("wr_obs_byte", {15'd0, obs[i]}, {15'd0, 1'b1, 8'(8'h10 + i), w[8*i +: 8]});

    // Test 3: unaligned read back
    obs.delete();
    do_req(1'b0, 8'h13, $urandom, rd);
    check("rd_word_10", rd, 32'hA1B2C3D4);
    check("rd_obs_count", obs.size(), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++)
      check("rd_obs_adr", {15'd0, obs[i][16:8]}, {15'd0, 1'b0, 8'(8'h10 + i)});

    // Test 4: back-to-back requests with req_valid held high
    @(posedge clk);
    dut_acc = 0;
    for (int c = 0; c < 30; c++) begin
      #2;
      req_valid = 1'b1;
      req_write = (n_acc % 2 == 0);
      req_adr   = ((n_acc / 2) % 2 == 0) ? 8'h20 : 8'h24;
      req_wdata = $urandom;
      @(posedge clk);
    end
    #2 req_valid = 1'b0;
    repeat (8) @(posedge clk);
    check("b2b_accepts", dut_acc, 5);

    // Test 5: reset during cnt=2 of a write
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b1; req_adr = 8'h30; req_wdata = 32'h11223344;
    @(posedge clk); #2 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("mid_adr",       {24'd0, mem_adr},       32'h32);
    check("mid_writedata", {24'd0, mem_writedata}, 32'h22);
    reset_n = 1'b0;
    #1;
    check("mid_rst_memwrite", {31'd0, mem_memwrite}, 32'd0);
    check("mid_rst_rsp",      {31'd0, rsp_valid},    32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    do_req(1'b0, 8'h30, $urandom, rd);
    check("partial_write_word", rd, 32'hFFFF3344);

    // Test 6: top word of the address space
    obs.delete();
    do_req(1'b0, 8'hFE, $urandom, rd);
    check("top_word", rd, 32'hDEADBEEF);
    check("top_obs_count", obs.size(), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++)
      check("top_obs_adr", {24'd0, obs[i][15:8]}, {24'd0, 8'(8'hFC + i)});

    // Random traffic, mostly around a small window to get read-after-write hits
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #2;
      req_valid = ($urandom % 3 == 0);
      req_write = 1'($urandom);
      req_adr   = ($urandom % 2 == 1) ? {4'h4, 4'($urandom)} : 8'($urandom);
      req_wdata = $urandom;
    end
    @(posedge clk); #2 req_valid = 1'b0;
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
